dispense_controller: RTL and testbench

//  Sequential stage downstream of fluid_dispenser. Accepts one priced order
//  (fluid_type, volume_l, final_price), collects coin payment and meters the

---
 rtl/dispense_controller_pkg.sv | 57 +++++
 rtl/dispense_controller_meter.sv | 49 ++++
 rtl/dispense_controller.sv | 208 ++++++++++++++++++++
 tb/tb_dispense_controller.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispense_controller_pkg.sv
// Shared definitions for the dispense controller slice.
// Holds the fluid codes (same encoding as price_calculator), the FSM state
// codes, the bus widths and small helpers shared by the top and the meter.
package dispense_controller_pkg;

    localparam int unsigned FLUID_W = 2;
    localparam int unsigned VOL_W   = 8;
    localparam int unsigned PRICE_W = 16;
    localparam int unsigned COIN_W  = 8;
    localparam int unsigned STOCK_W = 16;
    localparam int unsigned VALVE_W = 3;
    localparam int unsigned STATE_W = 3;

    // Fluid codes
    localparam logic [FLUID_W-1:0] FL_WATER = 2'b00;
    localparam logic [FLUID_W-1:0] FL_JUICE = 2'b01;
    localparam logic [FLUID_W-1:0] FL_CHEM  = 2'b10;
    localparam logic [FLUID_W-1:0] FL_INV   = 2'b11;

    // State codes
    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_REJECT   = 3'd1;
    localparam logic [STATE_W-1:0] ST_PAY      = 3'd2;
    localparam logic [STATE_W-1:0] ST_DISPENSE = 3'd3;
    localparam logic [STATE_W-1:0] ST_SETTLE   = 3'd4;
    localparam logic [STATE_W-1:0] ST_REFUND   = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = ST_IDLE,
        REJECT   = ST_REJECT,
        PAY      = ST_PAY,
        DISPENSE = ST_DISPENSE,
        SETTLE   = ST_SETTLE,
        REFUND   = ST_REFUND
    } state_t;

    // Payment accumulation saturating at all-ones
    function automatic logic [PRICE_W-1:0] sat_add(input logic [PRICE_W-1:0] a,
                                                   input logic [COIN_W-1:0]  b);
        logic [PRICE_W:0] sum;
        sum = (PRICE_W+1)'(a) + (PRICE_W+1)'(b);
        return sum[PRICE_W] ? {PRICE_W{1'b1}} : sum[PRICE_W-1:0];
    endfunction

    // One-hot valve select {chem,juice,water}
    function automatic logic [VALVE_W-1:0] fluid_valve(input logic [FLUID_W-1:0] fl);
        logic [VALVE_W-1:0] v;
        case (fl)
            FL_WATER: v = 3'b001;
            FL_JUICE: v = 3'b010;
            FL_CHEM:  v = 3'b100;
            default:  v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dispense_controller_meter.sv
// litre_meter: counts valve-open clocks and delivered litres.
// Ports:
//   clk, reset      clock / synchronous active-high reset
//   start           clears both counters (new order accepted)
//   enable          valve is open this cycle
//   volume          litres requested for the order
//   litres          litres delivered so far (registered)
//   litre_tick_c    this cycle completes a litre
//   meter_done_c    this cycle completes the last requested litre
module litre_meter
    import dispense_controller_pkg::*;
#(
    parameter int unsigned TICKS_PER_LITRE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic [VOL_W-1:0] volume,
    output logic [VOL_W-1:0] litres,
    output logic             litre_tick_c,
    output logic             meter_done_c
);

    localparam int unsigned TICK_W = (TICKS_PER_LITRE > 1) ? $clog2(TICKS_PER_LITRE) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_LITRE - 1);

    logic [TICK_W-1:0] tick_q;

    assign litre_tick_c = enable && (tick_q == TICK_LAST);
    // litres < volume whenever enabled, so the increment cannot wrap here
    assign meter_done_c = litre_tick_c && ((litres + VOL_W'(1)) == volume);

    // Tick and litre counters
    always_ff @(posedge clk) begin
        if (reset || start) begin
            tick_q <= '0;
            litres <= '0;
        end else if (enable) begin
            if (litre_tick_c) begin
                tick_q <= '0;
                litres <= litres + VOL_W'(1);
            end else begin
                tick_q <= tick_q + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/dispense_controller.sv
// dispense_controller: takes one priced order, collects coins, meters the
// fluid litre by litre through a per-fluid valve, tracks live stock and
// returns change or a refund.
// Ports:
//   clk, reset                  clock / synchronous active-high reset
//   order_valid/order_ready     order handshake (ready only in IDLE)
//   fluid_type, volume_l,
//   final_price                 order payload
//   coin_valid, coin_value      one coin per cycle
//   cancel                      customer abort, honoured while paying
//   valve_open                  one-hot {chem,juice,water}
//   litres_done, paid           progress of the current order
//   change_valid, change_amount change / refund pulse
//   done, reject                completion / refusal pulses
//   stock_water/juice/chem      live stock levels
module dispense_controller
    import dispense_controller_pkg::*;
#(
    parameter int unsigned TICKS_PER_LITRE = 4,
    parameter int unsigned PAY_TIMEOUT     = 255,
    parameter int unsigned WATER_INIT      = 100,
    parameter int unsigned JUICE_INIT      = 80,
    parameter int unsigned CHEM_INIT       = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               order_valid,
    output logic               order_ready,
    input  logic [FLUID_W-1:0] fluid_type,
    input  logic [VOL_W-1:0]   volume_l,
    input  logic [PRICE_W-1:0] final_price,
    input  logic               coin_valid,
    input  logic [COIN_W-1:0]  coin_value,
    input  logic               cancel,
    output logic [VALVE_W-1:0] valve_open,
    output logic [VOL_W-1:0]   litres_done,
    output logic [PRICE_W-1:0] paid,
    output logic               change_valid,
    output logic [PRICE_W-1:0] change_amount,
    output logic               done,
    output logic               reject,
    output logic [STOCK_W-1:0] stock_water,
    output logic [STOCK_W-1:0] stock_juice,
    output logic [STOCK_W-1:0] stock_chem
);

    localparam int unsigned TO_W = $clog2(PAY_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(PAY_TIMEOUT - 1);

    state_t             state_q, state_nxt;
    logic [FLUID_W-1:0] fluid_q, fluid_nxt;
    logic [VOL_W-1:0]   volume_q, volume_nxt;
    logic [PRICE_W-1:0] price_q, price_nxt;
    logic [PRICE_W-1:0] paid_nxt;
    logic [TO_W-1:0]    idle_q, idle_nxt;
    logic [STOCK_W-1:0] stock_sel_c;
    logic               meter_start;
    logic               litre_tick;
    logic               meter_done;

    logic               order_ready_nxt;
    logic [VALVE_W-1:0] valve_nxt;
    logic               change_valid_nxt;
    logic [PRICE_W-1:0] change_amount_nxt;
    logic               done_nxt;
    logic               reject_nxt;

    litre_meter #(
        .TICKS_PER_LITRE (TICKS_PER_LITRE)
    ) u_meter (
        .clk          (clk),
        .reset        (reset),
        .start        (meter_start),
        .enable       (state_q == DISPENSE),
        .volume       (volume_q),
        .litres       (litres_done),
        .litre_tick_c (litre_tick),
        .meter_done_c (meter_done)
    );

    // Stock level of the fluid being ordered, for the accept-time check
    always_comb begin
        stock_sel_c = '0;
        case (fluid_type)
            FL_WATER: stock_sel_c = stock_water;
            FL_JUICE: stock_sel_c = stock_juice;
            FL_CHEM:  stock_sel_c = stock_chem;
            default:  stock_sel_c = '0;
        endcase
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_nxt   = state_q;
        fluid_nxt   = fluid_q;
        volume_nxt  = volume_q;
        price_nxt   = price_q;
        paid_nxt    = paid;
        idle_nxt    = idle_q;
        meter_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (order_valid) begin
                    fluid_nxt   = fluid_type;
                    volume_nxt  = volume_l;
                    price_nxt   = final_price;
                    paid_nxt    = '0;
                    idle_nxt    = '0;
                    meter_start = 1'b1;
                    if ((fluid_type == FL_INV) || (volume_l == '0) ||
                        (STOCK_W'(volume_l) > stock_sel_c)) begin
                        state_nxt = REJECT;
                    end else begin
                        state_nxt = PAY;
                    end
                end
            end
            REJECT: state_nxt = IDLE;
            PAY: begin
                if (coin_valid) begin
                    paid_nxt = sat_add(paid, coin_value);
                    idle_nxt = '0;
                end else begin
                    idle_nxt = idle_q + TO_W'(1);
                end
                // cancel beats timeout beats a completed payment
                if (cancel) begin
                    state_nxt = REFUND;
                end else if (!coin_valid && (idle_q == TO_LAST)) begin
                    state_nxt = REFUND;
                end else if (paid_nxt >= price_q) begin
                    state_nxt = DISPENSE;
                end
            end
            DISPENSE: begin
                if (meter_done) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE:  state_nxt = IDLE;
            REFUND:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it
        order_ready_nxt   = (state_nxt == IDLE);
        valve_nxt         = (state_nxt == DISPENSE) ? fluid_valve(fluid_nxt) : '0;
        reject_nxt        = (state_nxt == REJECT);
        done_nxt          = (state_nxt == SETTLE);
        change_valid_nxt  = (state_nxt == SETTLE) || (state_nxt == REFUND);
        change_amount_nxt = '0;
        if (state_nxt == SETTLE) begin
            change_amount_nxt = paid_nxt - price_nxt;
        end else if (state_nxt == REFUND) begin
            change_amount_nxt = paid_nxt;
        end
    end

    // State, order registers and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            fluid_q       <= FL_WATER;
            volume_q      <= '0;
            price_q       <= '0;
            paid          <= '0;
            idle_q        <= '0;
            order_ready   <= 1'b1;
            valve_open    <= '0;
            reject        <= 1'b0;
            done          <= 1'b0;
            change_valid  <= 1'b0;
            change_amount <= '0;
        end else begin
            state_q       <= state_nxt;
            fluid_q       <= fluid_nxt;
            volume_q      <= volume_nxt;
            price_q       <= price_nxt;
            paid          <= paid_nxt;
            idle_q        <= idle_nxt;
            order_ready   <= order_ready_nxt;
            valve_open    <= valve_nxt;
            reject        <= reject_nxt;
            done          <= done_nxt;
            change_valid  <= change_valid_nxt;
            change_amount <= change_amount_nxt;
        end
    end

    // Live stock; only decremented on a completed litre, never below zero
    // because the accept check guarantees enough stock for the whole order
    always_ff @(posedge clk) begin
        if (reset) begin
            stock_water <= STOCK_W'(WATER_INIT);
            stock_juice <= STOCK_W'(JUICE_INIT);
            stock_chem  <= STOCK_W'(CHEM_INIT);
        end else if (litre_tick) begin
            case (fluid_q)
                FL_WATER: stock_water <= stock_water - STOCK_W'(1);
                FL_JUICE: stock_juice <= stock_juice - STOCK_W'(1);
                FL_CHEM:  stock_chem  <= stock_chem - STOCK_W'(1);
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_dispense_controller.sv
// Bench for dispense_controller: directed orders, an order-level timeline
// model producing expected outputs per cycle, and one compare process.
module tb_dispense_controller;

    localparam int T       = 4;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        order_valid;
    logic        order_ready;
    logic [1:0]  fluid_type;
    logic [7:0]  volume_l;
    logic [15:0] final_price;
    logic        coin_valid;
    logic [7:0]  coin_value;
    logic        cancel;
    logic [2:0]  valve_open;
    logic [7:0]  litres_done;
    logic [15:0] paid;
    logic        change_valid;
    logic [15:0] change_amount;
    logic        done;
    logic        reject;
    logic [15:0] stock_water;
    logic [15:0] stock_juice;
    logic [15:0] stock_chem;

    dispense_controller #(
        .TICKS_PER_LITRE (T),
        .PAY_TIMEOUT     (TIMEOUT),
        .WATER_INIT      (100),
        .JUICE_INIT      (80),
        .CHEM_INIT       (60)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .order_valid   (order_valid),
        .order_ready   (order_ready),
        .fluid_type    (fluid_type),
        .volume_l      (volume_l),
        .final_price   (final_price),
        .coin_valid    (coin_valid),
        .coin_value    (coin_value),
        .cancel        (cancel),
        .valve_open    (valve_open),
        .litres_done   (litres_done),
        .paid          (paid),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .done          (done),
        .reject        (reject),
        .stock_water   (stock_water),
        .stock_juice   (stock_juice),
        .stock_chem    (stock_chem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic [2:0]  valve;
        logic [7:0]  litres;
        logic [15:0] paid;
        logic        cv;
        logic [15:0] change;
        logic        done;
        logic        rej;
        logic [15:0] sw;
        logic [15:0] sj;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cmp_e;

    int n_checks = 0;
    int n_errors = 0;
    int cycle_n  = 0;

    // Model state carried between orders
    int m_stock[4];
    int m_paid;
    int m_litres;

    // Per-order stimulus schedule
    int coin_sched[0:1023];
    int cancel_k;
    bit noise;
    int abort_litres;

    // Observation counters kept by the compare process
    int valve_cycles  = 0;
    int busy_cycles   = 0;
    int change_pulses = 0;
    int last_change   = -1;

    function automatic void chk(input string name, input int unsigned act, input int unsigned expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycle_n, act, expv);
        end
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.ready  = 1'b1;
        e.valve  = 3'b000;
        e.litres = 8'(m_litres);
        e.paid   = 16'(m_paid);
        e.cv     = 1'b0;
        e.change = 16'd0;
        e.done   = 1'b0;
        e.rej    = 1'b0;
        e.sw     = 16'(m_stock[0]);
        e.sj     = 16'(m_stock[1]);
        e.sc     = 16'(m_stock[2]);
        return e;
    endfunction

    function automatic void clear_sched();
        for (int i = 0; i < 1024; i++) coin_sched[i] = 0;
        cancel_k     = -1;
        noise        = 1'b0;
        abort_litres = -1;
    endfunction

    // One cycle: register what the outputs must be in this cycle, then advance
    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Single compare process
    always @(negedge clk) begin
        cycle_n++;
        if (valve_open != 3'b000) valve_cycles++;
        if (!order_ready)         busy_cycles++;
        if (change_valid) begin
            change_pulses++;
            last_change = int'(change_amount);
        end
        if (exp_q.size() != 0) begin
            cmp_e = exp_q.pop_front();
            chk("order_ready",   order_ready,   cmp_e.ready);
            chk("valve_open",    valve_open,    cmp_e.valve);
            chk("litres_done",   litres_done,   cmp_e.litres);
            chk("paid",          paid,          cmp_e.paid);
            chk("change_valid",  change_valid,  cmp_e.cv);
            chk("change_amount", change_amount, cmp_e.change);
            chk("done",          done,          cmp_e.done);
            chk("reject",        reject,        cmp_e.rej);
            chk("stock_water",   stock_water,   cmp_e.sw);
            chk("stock_juice",   stock_juice,   cmp_e.sj);
            chk("stock_chem",    stock_chem,    cmp_e.sc);
        end
    end

    // Plays one order and builds its expected timeline from order-level rules
    task automatic run_order(input logic [1:0] fl, input int vol, input int price);
        exp_t e;
        int   run;
        bit   refund;
        int   s[4];
        int   dlen;

        order_valid = 1'b1;
        fluid_type  = fl;
        volume_l    = 8'(vol);
        final_price = 16'(price);
        step(idle_exp());
        order_valid = 1'b0;
        m_paid   = 0;
        m_litres = 0;

        if (fl == 2'b11 || vol == 0 || vol > m_stock[fl]) begin
            e = idle_exp();
            e.ready = 1'b0;
            e.rej   = 1'b1;
            step(e);
            step(idle_exp());
            return;
        end

        run    = 0;
        refund = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            coin_valid = (coin_sched[k] != 0);
            coin_value = 8'(coin_sched[k]);
            cancel     = (k == cancel_k);
            e = idle_exp();
            e.ready = 1'b0;
            step(e);
            if (coin_sched[k] != 0) begin
                m_paid = (m_paid + coin_sched[k] > 65535) ? 65535 : m_paid + coin_sched[k];
                run    = 0;
            end else begin
                run++;
            end
            if (k == cancel_k || run == TIMEOUT) begin
                refund = 1'b1;
                break;
            end
            if (m_paid >= price) break;
        end
        coin_valid = 1'b0;
        cancel     = 1'b0;

        if (refund) begin
            e = idle_exp();
            e.ready  = 1'b0;
            e.cv     = 1'b1;
            e.change = 16'(m_paid);
            step(e);
            step(idle_exp());
            return;
        end

        dlen = vol * T;
        for (int j = 0; j < dlen; j++) begin
            if (noise) begin
                coin_valid = ((j % 2) == 1);
                coin_value = 8'd7;
                cancel     = ((j % 2) == 1);
            end
            s = m_stock;
            s[fl] = s[fl] - j / T;
            e = idle_exp();
            e.ready  = 1'b0;
            e.valve  = 3'(1 << fl);
            e.litres = 8'(j / T);
            e.sw     = 16'(s[0]);
            e.sj     = 16'(s[1]);
            e.sc     = 16'(s[2]);
            if (abort_litres >= 0 && j == abort_litres * T) begin
                reset = 1'b1;
                step(e);
                reset      = 1'b0;
                coin_valid = 1'b0;
                cancel     = 1'b0;
                m_stock    = '{100, 80, 60, 0};
                m_paid     = 0;
                m_litres   = 0;
                step(idle_exp());
                return;
            end
            step(e);
        end
        coin_valid = 1'b0;
        cancel     = 1'b0;

        m_stock[fl] = m_stock[fl] - vol;
        m_litres    = vol;
        e = idle_exp();
        e.ready  = 1'b0;
        e.cv     = 1'b1;
        e.change = 16'(m_paid - price);
        e.done   = 1'b1;
        step(e);
        step(idle_exp());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running expected=finished", cycle_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vc0, bc0, cp0;

        reset       = 1'b1;
        order_valid = 1'b0;
        fluid_type  = 2'b00;
        volume_l    = 8'd0;
        final_price = 16'd0;
        coin_valid  = 1'b0;
        coin_value  = 8'd0;
        cancel      = 1'b0;
        m_stock     = '{100, 80, 60, 0};
        m_paid      = 0;
        m_litres    = 0;
        clear_sched();

        @(posedge clk);
        #1;
        step(idle_exp());
        reset = 1'b0;
        step(idle_exp());

        // Reset state pinned by literals
        chk("rst_order_ready", order_ready, 1);
        chk("rst_valve", valve_open, 0);
        chk("rst_paid", paid, 0);
        chk("rst_stock_water", stock_water, 100);
        chk("rst_stock_juice", stock_juice, 80);
        chk("rst_stock_chem", stock_chem, 60);

        // 1: water 3 L, price 50, coins 20,20,20; coins/cancel while dispensing are ignored
        clear_sched();
        coin_sched[0] = 20; coin_sched[1] = 20; coin_sched[2] = 20;
        noise = 1'b1;
        vc0 = valve_cycles; bc0 = busy_cycles;
        run_order(2'b00, 3, 50);
        chk("t1_stock_water", stock_water, 97);
        chk("t1_valve_cycles", valve_cycles - vc0, 12);
        chk("t1_change", last_change, 10);
        chk("t1_busy_cycles", busy_cycles - bc0, 16);
        chk("t1_litres_done", litres_done, 3);

        // 2: juice 81 L exceeds stock
        clear_sched();
        bc0 = busy_cycles;
        run_order(2'b01, 81, 10);
        chk("t2_stock_juice", stock_juice, 80);
        chk("t2_busy_cycles", busy_cycles - bc0, 1);
        chk("t2_order_ready", order_ready, 1);

        // 3: chem, coin 10 then cancel
        clear_sched();
        coin_sched[0] = 10;
        cancel_k = 2;
        vc0 = valve_cycles;
        run_order(2'b10, 2, 40);
        chk("t3_change", last_change, 10);
        chk("t3_valve_cycles", valve_cycles - vc0, 0);
        chk("t3_stock_chem", stock_chem, 60);

        // 4a: no coins -> timeout refund of 0
        clear_sched();
        bc0 = busy_cycles; cp0 = change_pulses;
        run_order(2'b00, 1, 30);
        chk("t4a_busy_cycles", busy_cycles - bc0, TIMEOUT + 1);
        chk("t4a_change", last_change, 0);
        chk("t4a_change_pulses", change_pulses - cp0, 1);

        // 4b: coin on the 254th idle cycle restarts the timeout
        clear_sched();
        coin_sched[253] = 5;
        bc0 = busy_cycles;
        run_order(2'b00, 1, 30);
        chk("t4b_busy_cycles", busy_cycles - bc0, 254 + TIMEOUT + 1);
        chk("t4b_change", last_change, 5);

        // 5: juice 80 L free, empties the tank; then juice 1 L is refused
        clear_sched();
        vc0 = valve_cycles;
        run_order(2'b01, 80, 0);
        chk("t5_valve_cycles", valve_cycles - vc0, 320);
        chk("t5_stock_juice", stock_juice, 0);
        clear_sched();
        bc0 = busy_cycles;
        run_order(2'b01, 1, 0);
        chk("t5b_busy_cycles", busy_cycles - bc0, 1);
        chk("t5b_stock_juice", stock_juice, 0);

        // Invalid fluid and zero volume are refused
        clear_sched();
        run_order(2'b11, 1, 0);
        clear_sched();
        run_order(2'b00, 0, 0);

        // 6: reset during dispense after 2 litres
        clear_sched();
        abort_litres = 2;
        cp0 = change_pulses;
        run_order(2'b00, 5, 0);
        chk("t6_stock_water", stock_water, 100);
        chk("t6_stock_juice", stock_juice, 80);
        chk("t6_valve", valve_open, 0);
        chk("t6_change_pulses", change_pulses - cp0, 0);
        chk("t6_litres_done", litres_done, 0);

        @(negedge clk);
        #1;
        chk("exp_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
